// File: rtl/prio_irq_ctrl.sv
// rtl/prio_irq_ctrl.sv - four-line prioritised interrupt controller with pend/lost tracking
// Captures requests into a pending register and presents the highest unmasked line without preemption.

module prio_irq_ctrl #(
   parameter int EDGE = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic [3:0] mask,
   input  logic       irq_ready,
   input  logic       clr_lost,
   output logic       irq_valid,
   output logic [1:0] irq_id,
   output logic [3:0] pend,
   output logic [3:0] lost
);

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] id_q, id_d;
   logic [3:0] req_q;
   logic [3:0] pend_q, pend_d;
   logic [3:0] lost_q, lost_d;
   logic [3:0] set;
   logic [3:0] clr;
   logic [3:0] cand;
   logic [1:0] sel_id;
   logic       accept;

   // req_q keeps tracking req through reset so a line held high across release shows no edge.
   always_ff @(posedge clk) begin
      req_q <= req;
   end

   always_comb begin
      if (EDGE != 0) begin
         set = req & ~req_q;
      end else begin
         set = req;
      end
   end

   assign accept = (state_q == PRESENT) && irq_ready;
   assign clr    = accept ? (4'b0001 << id_q) : 4'b0000;
   assign cand   = pend_q & mask;

   always_comb begin
      sel_id = 2'd0;
      if (cand[3]) begin
         sel_id = 2'd3;
      end else if (cand[2]) begin
         sel_id = 2'd2;
      end else if (cand[1]) begin
         sel_id = 2'd1;
      end else begin
         sel_id = 2'd0;
      end
   end

   // A new capture overrides a same-cycle acknowledge, and only counts as lost if not being cleared.
   always_comb begin
      pend_d = (pend_q & ~clr) | set;
      lost_d = (clr_lost ? 4'b0000 : lost_q) | (set & pend_q & ~clr);
   end

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      case (state_q)
         IDLE: begin
            if (cand != 4'b0000) begin
               state_d = PRESENT;
               id_d    = sel_id;
            end
         end
         PRESENT: begin
            if (irq_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         id_q    <= 2'd0;
         pend_q  <= 4'b0000;
         lost_q  <= 4'b0000;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         pend_q  <= pend_d;
         lost_q  <= lost_d;
      end
   end

   assign irq_valid = (state_q == PRESENT);
   assign irq_id    = id_q;
   assign pend      = pend_q;
   assign lost      = lost_q;

endmodule

// File: tb/tb_prio_irq_ctrl.sv
// tb/tb_prio_irq_ctrl.sv - self-checking bench for prio_irq_ctrl (EDGE=1)
// A per-bit behavioural model is compared every cycle; directed literals pin key points.

module tb_prio_irq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] mask;
   logic       irq_ready;
   logic       clr_lost;
   logic       irq_valid;
   logic [1:0] irq_id;
   logic [3:0] pend;
   logic [3:0] lost;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   prio_irq_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .mask      (mask),
      .irq_ready (irq_ready),
      .clr_lost  (clr_lost),
      .irq_valid (irq_valid),
      .irq_id    (irq_id),
      .pend      (pend),
      .lost      (lost)
   );

   typedef struct packed {
      logic [3:0] pend;
      logic [3:0] lost;
      logic       busy;
      logic [1:0] id;
   } mstate_t;

   mstate_t    m;
   logic [3:0] m_reqq;

   function automatic mstate_t model_next(mstate_t s, logic [3:0] prev_r, logic [3:0] r,
                                          logic [3:0] mk, logic rdy, logic cl, logic reset);
      mstate_t n;
      bit      found;
      bit      rise;
      bit      taken;
      n     = s;
      found = 1'b0;
      if (reset) begin
         n = '0;
         return n;
      end
      if (cl) n.lost = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         rise  = r[i] && !prev_r[i];
         taken = s.busy && rdy && (int'(s.id) == i);
         if (taken) n.pend[i] = 1'b0;
         if (rise) begin
            if (s.pend[i] && !taken) n.lost[i] = 1'b1;
            n.pend[i] = 1'b1;
         end
      end
      if (s.busy) begin
         n.busy = !rdy;
      end else begin
         for (int i = 3; i >= 0; i--) begin
            if (!found && s.pend[i] && mk[i]) begin
               found  = 1'b1;
               n.busy = 1'b1;
               n.id   = 2'(i);
            end
         end
      end
      return n;
   endfunction

   always @(posedge clk) begin
      m      <= model_next(m, m_reqq, req, mask, irq_ready, clr_lost, rst);
      m_reqq <= req;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_irq_valid", 32'(irq_valid), 32'(m.busy));
         check("model_irq_id",    32'(irq_id),    32'(m.id));
         check("model_pend",      32'(pend),      32'(m.pend));
         check("model_lost",      32'(lost),      32'(m.lost));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst       = 1'b1;
      req       = 4'b0000;
      mask      = 4'b1111;
      irq_ready = 1'b0;
      clr_lost  = 1'b0;
      tick(3);
      chk_en = 1'b1;
      check("reset_valid", 32'(irq_valid), 32'd0);
      check("reset_id",    32'(irq_id),    32'd0);
      check("reset_pend",  32'(pend),      32'h0);
      check("reset_lost",  32'(lost),      32'h0);
      rst = 1'b0;

      // single request
      tick(1); req = 4'b0100;
      tick(1); req = 4'b0000;
      check("single_pend", 32'(pend), 32'h4);
      check("single_valid_early", 32'(irq_valid), 32'd0);
      tick(1);
      check("single_valid", 32'(irq_valid), 32'd1);
      check("single_id", 32'(irq_id), 32'd2);
      irq_ready = 1'b1;
      tick(1); irq_ready = 1'b0;
      check("single_done_pend", 32'(pend), 32'h0);
      check("single_done_valid", 32'(irq_valid), 32'd0);

      // set wins over same-cycle acknowledge
      tick(1); req = 4'b0100;
      tick(1); req = 4'b0000;
      tick(1);
      check("setclr_valid", 32'(irq_valid), 32'd1);
      irq_ready = 1'b1; req = 4'b0100;
      tick(1); irq_ready = 1'b0; req = 4'b0000;
      check("setclr_pend", 32'(pend), 32'h4);
      check("setclr_lost", 32'(lost), 32'h0);
      tick(1);
      check("setclr_again_id", 32'(irq_id), 32'd2);
      irq_ready = 1'b1;
      tick(1); irq_ready = 1'b0;
      check("setclr_final_pend", 32'(pend), 32'h0);

      // priority order with idle gaps
      irq_ready = 1'b1; req = 4'b1111;
      tick(1); req = 4'b0000;
      check("prio_pend", 32'(pend), 32'hF);
      for (int i = 0; i < 8; i++) begin
         tick(1);
         check("prio_valid", 32'(irq_valid), (i % 2 == 0) ? 32'd1 : 32'd0);
         if (i % 2 == 0) check("prio_id", 32'(irq_id), 32'(3 - i / 2));
      end
      check("prio_final_pend", 32'(pend), 32'h0);
      irq_ready = 1'b0;

      // no preemption
      tick(1); req = 4'b0001;
      tick(1); req = 4'b0000;
      tick(1);
      check("nopre_id0", 32'(irq_id), 32'd0);
      req = 4'b1000;
      tick(1); req = 4'b0000;
      tick(2);
      check("nopre_valid", 32'(irq_valid), 32'd1);
      check("nopre_id_held", 32'(irq_id), 32'd0);
      check("nopre_pend", 32'(pend), 32'h9);
      irq_ready = 1'b1;
      tick(1); irq_ready = 1'b0;
      check("nopre_gap", 32'(irq_valid), 32'd0);
      tick(1);
      check("nopre_id3", 32'(irq_id), 32'd3);
      check("nopre_valid3", 32'(irq_valid), 32'd1);
      irq_ready = 1'b1;
      tick(1); irq_ready = 1'b0;

      // masking
      mask = 4'b0111; req = 4'b1001;
      tick(1); req = 4'b0000;
      tick(1);
      check("mask_id0", 32'(irq_id), 32'd0);
      irq_ready = 1'b1;
      tick(1); irq_ready = 1'b0;
      tick(2);
      check("mask_held_pend", 32'(pend), 32'h8);
      check("mask_held_valid", 32'(irq_valid), 32'd0);
      mask = 4'b1111;
      tick(1);
      check("mask_id3", 32'(irq_id), 32'd3);
      irq_ready = 1'b1;
      tick(1); irq_ready = 1'b0;

      // lost flags
      mask = 4'b1101; req = 4'b0010;
      tick(1); req = 4'b0000;
      tick(1); req = 4'b0010;
      tick(1); req = 4'b0000;
      check("lost_set", 32'(lost), 32'h2);
      check("lost_pend", 32'(pend), 32'h2);
      clr_lost = 1'b1;
      tick(1); clr_lost = 1'b0;
      check("lost_clr", 32'(lost), 32'h0);
      req = 4'b0010; clr_lost = 1'b1;
      tick(1); req = 4'b0000; clr_lost = 1'b0;
      check("lost_set_wins", 32'(lost), 32'h2);
      clr_lost = 1'b1;
      tick(1); clr_lost = 1'b0;
      mask = 4'b1111;
      tick(1);
      check("lost_present_id1", 32'(irq_id), 32'd1);
      irq_ready = 1'b1;
      tick(1); irq_ready = 1'b0;
      check("lost_final_pend", 32'(pend), 32'h0);

      // reset behaviour
      rst = 1'b1; req = 4'b1111;
      tick(2); rst = 1'b0;
      tick(3);
      check("rst_hold_pend", 32'(pend), 32'h0);
      check("rst_hold_valid", 32'(irq_valid), 32'd0);
      req = 4'b0000;
      tick(1); req = 4'b0100;
      tick(1); req = 4'b0000;
      tick(1);
      check("rst_mid_valid_before", 32'(irq_valid), 32'd1);
      rst = 1'b1;
      tick(1); rst = 1'b0;
      check("rst_mid_valid", 32'(irq_valid), 32'd0);
      check("rst_mid_pend", 32'(pend), 32'h0);
      tick(2);
      check("rst_after_valid", 32'(irq_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/prio_irq_ctrl.md
PRIO_IRQ_CTRL -- requirements
Module: prio_irq_ctrl

Interface
REQ-001 SHALL have parameter: EDGE, default 1, request capture mode (1 = rising-edge capture, 0 = level capture).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: req  input  4  raw request lines; req[3] highest priority, req[0] lowest.
REQ-005 SHALL have port: mask  input  4  per-line enable; 1 = line may be presented, 0 = line held pending but not presented.
REQ-006 SHALL have port: irq_ready  input  1  consumer accepts the presented request.
REQ-007 SHALL have port: clr_lost  input  1  single-cycle pulse that clears the lost flags.
REQ-008 SHALL have port: irq_valid  output  1  a request is presented on irq_id.
REQ-009 SHALL have port: irq_id  output  2  binary index of the presented line.
REQ-010 SHALL have port: pend  output  4  pending register, registered.
REQ-011 SHALL have port: lost  output  4  sticky per-line overflow flags, registered.

Function
REQ-012 SHALL register req into req_q every cycle, including during reset.
REQ-013 SHALL compute set = req & ~req_q when EDGE=1, and set = req when EDGE=0.
REQ-014 SHALL update pend <= (pend & ~clr) | set, where clr is the one-hot of irq_id when irq_valid & irq_ready, else 0.
- If set and clr hit the same bit in the same cycle, set wins and the bit stays pending.
REQ-015 SHALL form cand = pend & mask and select the highest set index of cand (3 > 2 > 1 > 0).
REQ-016 SHALL implement a two-state FSM, IDLE and PRESENT:
- IDLE -> PRESENT when cand != 0; irq_id is latched with the selected index on that edge.
- PRESENT -> IDLE on irq_valid & irq_ready.
- Otherwise PRESENT holds.
REQ-017 SHALL drive irq_valid = 1 only in PRESENT.
- irq_id is held stable throughout PRESENT.
- No preemption: a higher-priority arrival, a mask change or a pend change does not alter irq_id or drop irq_valid.
REQ-018 SHALL return to IDLE for at least one cycle after every accepted handshake, so back-to-back presentations are separated by one irq_valid-low cycle.
REQ-019 SHALL have latency as follows, when idle and unmasked:
- req rises before edge k; pend bit is set after edge k.
- PRESENT (irq_valid=1) is entered after edge k+1.
REQ-020 SHALL keep masked pending bits pending indefinitely; unmasking one makes it eligible on the next IDLE evaluation.
REQ-021 SHALL set lost[i] when set[i]=1 while pend[i]=1 and bit i is not being cleared that cycle.
- The lost flag is sticky.
REQ-022 SHALL clear all lost bits on clr_lost, except that a lost set in the same cycle wins.
REQ-023 SHALL, in level mode (EDGE=0), re-pend a line whose req is still high in the cycle after its acknowledge; this is not counted as lost while the bit is being cleared.

Reset
REQ-024 SHALL, while rst=1, drive pend=0, lost=0, FSM=IDLE, irq_valid=0 and irq_id=0, with req_q loaded from req.
- A req held high through reset release produces no edge in EDGE=1.
REQ-025 SHALL abandon an outstanding PRESENT when rst is asserted mid-handshake.
- irq_valid=0 after that edge, and the pending bit is discarded.

Verification
REQ-026 SHALL cover the single request: EDGE=1, mask=1111, pulse req=0100 for 1 cycle -> pend=0100 next cycle, irq_valid=1 and irq_id=2 one cycle later; irq_ready=1 -> pend=0000, irq_valid=0.
REQ-027 SHALL cover priority order: req=1111 in one cycle, irq_ready held 1 -> irq_id sequence 3,2,1,0, each with one idle cycle between; final pend=0000.
REQ-028 SHALL cover no preemption: present id 0 with irq_ready=0, then pulse req[3] -> irq_id stays 0 until accepted, then irq_id=3 is presented.
REQ-029 SHALL cover masking: mask=0111, req pulse 1001 -> id 0 is presented, pend[3] stays 1; set mask=1111 -> id 3 is presented.
REQ-030 SHALL cover lost flags: pulse req[1] twice while it is pending and unacknowledged -> lost=0010; clr_lost -> lost=0000.
REQ-031 SHALL cover reset: hold req=1111 through reset release (EDGE=1) -> pend stays 0000; assert rst during PRESENT -> irq_valid=0 and pend=0000 next cycle.
